// File: rtl/lexington_pkg.sv
// Shared types and default constants for the data-side RAM port arbiter.
package lexington_pkg;

  localparam int unsigned DEFAULT_RAM_ADDR_WIDTH    = 10;
  localparam int unsigned DEFAULT_RAM_ARB_MAX_WAIT  = 4;
  localparam int unsigned DEFAULT_RAM_ARB_MAX_BURST = 8;

  typedef enum logic [1:0] {CORE_OWN, DMA_FORCE, DMA_BURST} ram_arb_state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_DMA} ram_arb_owner_t;

endpackage

// File: rtl/ram_arb_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module ram_arb_sat_counter #(
  parameter int unsigned MAX_VAL = 4,
  parameter int unsigned WIDTH   = $clog2(MAX_VAL + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != WIDTH'(MAX_VAL))) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the data-side RAM port between the core DBus and a DMA master (core has priority).
// Optional RAM_ARB_STATS_EN adds conflict and forced-grant counters.
module ram_port_arbiter
  import lexington_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_RAM_ADDR_WIDTH,
  parameter int unsigned MAX_WAIT   = DEFAULT_RAM_ARB_MAX_WAIT,
  parameter int unsigned MAX_BURST  = DEFAULT_RAM_ARB_MAX_BURST
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_c_rd_en,
  input  logic                  i_c_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_c_addr,
  input  logic [31:0]           i_c_wr_data,
  input  logic [3:0]            i_c_wr_strobe,
  output logic                  o_c_busy,
  output logic [31:0]           o_c_rd_data,
  input  logic                  i_d_req,
  input  logic                  i_d_we,
  input  logic                  i_d_lock,
  input  logic [ADDR_WIDTH-1:0] i_d_addr,
  input  logic [31:0]           i_d_wr_data,
  input  logic [3:0]            i_d_wr_strobe,
  output logic                  o_d_gnt,
  output logic                  o_d_rd_valid,
  output logic [31:0]           o_d_rd_data,
  output logic                  o_ram_rd_en,
  output logic                  o_ram_wr_en,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [31:0]           o_ram_wr_data,
  output logic [3:0]            o_ram_wr_strobe,
`ifdef RAM_ARB_STATS_EN
  output logic [31:0]           o_stat_conflicts,
  output logic [31:0]           o_stat_forced,
`endif
  input  logic [31:0]           i_ram_rd_data
);

  localparam int unsigned WAIT_W  = $clog2(MAX_WAIT + 1);
  localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [BURST_W-1:0] BEAT_LAST = BURST_W'(MAX_BURST - 1);

  ram_arb_state_t       r_state, w_state_next;
  ram_arb_owner_t       r_rd_owner, w_rd_owner_next;
  logic                 w_core_req, w_core_win, w_dma_win;
  logic [WAIT_W-1:0]    w_wait;
  logic [BURST_W-1:0]   w_beat;

  assign w_core_req = i_c_rd_en | i_c_wr_en;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= CORE_OWN;
      r_rd_owner <= OWN_NONE;
    end else begin
      r_state    <= w_state_next;
      r_rd_owner <= w_rd_owner_next;
    end
  end

  always_comb begin
    w_dma_win    = 1'b0;
    w_state_next = r_state;
    if (!i_rst_n) begin
      w_state_next = CORE_OWN;
    end else begin
      unique case (r_state)
        CORE_OWN: begin
          if (w_core_req) begin
            // The increment happening this cycle lands on MAX_WAIT.
            if (i_d_req && (w_wait >= WAIT_LAST)) w_state_next = DMA_FORCE;
          end else if (i_d_req) begin
            w_dma_win = 1'b1;
            if (i_d_lock && (MAX_BURST > 1)) w_state_next = DMA_BURST;
          end
        end
        DMA_FORCE: begin
          w_dma_win    = i_d_req;
          w_state_next = CORE_OWN;
        end
        DMA_BURST: begin
          if (i_d_req && i_d_lock) begin
            w_dma_win = 1'b1;
            if (w_beat >= BEAT_LAST) w_state_next = CORE_OWN;
          end else begin
            w_state_next = CORE_OWN;
          end
        end
        default: w_state_next = CORE_OWN;
      endcase
    end
  end

  assign w_core_win = i_rst_n & w_core_req & ~w_dma_win;
  assign o_d_gnt    = w_dma_win;
  assign o_c_busy   = w_core_req & w_dma_win;

  ram_arb_sat_counter #(
    .MAX_VAL (MAX_WAIT),
    .WIDTH   (WAIT_W)
  ) u_wait_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (~i_d_req | w_dma_win),
    .i_inc   (i_d_req & ~w_dma_win),
    .o_count (w_wait)
  );

  ram_arb_sat_counter #(
    .MAX_VAL (MAX_BURST),
    .WIDTH   (BURST_W)
  ) u_beat_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_state_next != DMA_BURST),
    .i_inc   (w_dma_win),
    .o_count (w_beat)
  );

  // A simultaneous core read and write is issued as a write.
  always_comb begin
    o_ram_rd_en     = 1'b0;
    o_ram_wr_en     = 1'b0;
    o_ram_addr      = '0;
    o_ram_wr_data   = '0;
    o_ram_wr_strobe = '0;
    w_rd_owner_next = OWN_NONE;
    if (w_dma_win) begin
      o_ram_addr = i_d_addr;
      if (i_d_we) begin
        o_ram_wr_en     = 1'b1;
        o_ram_wr_data   = i_d_wr_data;
        o_ram_wr_strobe = i_d_wr_strobe;
      end else begin
        o_ram_rd_en     = 1'b1;
        w_rd_owner_next = OWN_DMA;
      end
    end else if (w_core_win) begin
      o_ram_addr = i_c_addr;
      if (i_c_wr_en) begin
        o_ram_wr_en     = 1'b1;
        o_ram_wr_data   = i_c_wr_data;
        o_ram_wr_strobe = i_c_wr_strobe;
      end else begin
        o_ram_rd_en     = 1'b1;
        w_rd_owner_next = OWN_CORE;
      end
    end
  end

  // Read data returned while reset is asserted is dropped.
  assign o_d_rd_valid = i_rst_n & (r_rd_owner == OWN_DMA);
  assign o_d_rd_data  = o_d_rd_valid ? i_ram_rd_data : 32'h0;
  assign o_c_rd_data  = (i_rst_n && (r_rd_owner == OWN_CORE)) ? i_ram_rd_data : 32'h0;

`ifdef RAM_ARB_STATS_EN
  logic [31:0] r_stat_conflicts, r_stat_forced;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_stat_conflicts <= '0;
      r_stat_forced    <= '0;
    end else begin
      if (w_core_req && i_d_req) r_stat_conflicts <= r_stat_conflicts + 32'd1;
      if ((w_state_next == DMA_FORCE) && (r_state != DMA_FORCE)) begin
        r_stat_forced <= r_stat_forced + 32'd1;
      end
    end
  end

  assign o_stat_conflicts = r_stat_conflicts;
  assign o_stat_forced    = r_stat_forced;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed and randomized bench for ram_port_arbiter against a behavioural arbitration model.
module tb_ram_port_arbiter;

  localparam int unsigned AW        = 10;
  localparam int unsigned MAX_WAIT  = 4;
  localparam int unsigned MAX_BURST = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          c_rd_en, c_wr_en, d_req, d_we, d_lock;
  logic [AW-1:0] c_addr, d_addr;
  logic [31:0]   c_wr_data, d_wr_data;
  logic [3:0]    c_wr_strobe, d_wr_strobe;
  logic          c_busy, d_gnt, d_rd_valid, ram_rd_en, ram_wr_en;
  logic [31:0]   c_rd_data, d_rd_data, ram_wr_data, ram_rd_data;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_wr_strobe;
`ifdef RAM_ARB_STATS_EN
  logic [31:0]   stat_conflicts, stat_forced;
`endif

  ram_port_arbiter #(
    .ADDR_WIDTH (AW),
    .MAX_WAIT   (MAX_WAIT),
    .MAX_BURST  (MAX_BURST)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_c_rd_en       (c_rd_en),
    .i_c_wr_en       (c_wr_en),
    .i_c_addr        (c_addr),
    .i_c_wr_data     (c_wr_data),
    .i_c_wr_strobe   (c_wr_strobe),
    .o_c_busy        (c_busy),
    .o_c_rd_data     (c_rd_data),
    .i_d_req         (d_req),
    .i_d_we          (d_we),
    .i_d_lock        (d_lock),
    .i_d_addr        (d_addr),
    .i_d_wr_data     (d_wr_data),
    .i_d_wr_strobe   (d_wr_strobe),
    .o_d_gnt         (d_gnt),
    .o_d_rd_valid    (d_rd_valid),
    .o_d_rd_data     (d_rd_data),
    .o_ram_rd_en     (ram_rd_en),
    .o_ram_wr_en     (ram_wr_en),
    .o_ram_addr      (ram_addr),
    .o_ram_wr_data   (ram_wr_data),
    .o_ram_wr_strobe (ram_wr_strobe),
`ifdef RAM_ARB_STATS_EN
    .o_stat_conflicts (stat_conflicts),
    .o_stat_forced    (stat_forced),
`endif
    .i_ram_rd_data   (ram_rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = din[8*b +: 8];
    return r;
  endfunction

  // RAM behind the arbiter: 64 words, unwritten words read as zero, cleared by reset.
  logic [31:0] ram_mem [0:63];
  logic [63:0] ram_vld;

  function automatic logic [31:0] ram_get(input logic [5:0] a);
    return ram_vld[a] ? ram_mem[a] : 32'h0;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      ram_vld     <= '0;
      ram_rd_data <= 32'h0;
    end else begin
      if (ram_wr_en) begin
        ram_mem[ram_addr[5:0]] <= merge(ram_get(ram_addr[5:0]), ram_wr_data, ram_wr_strobe);
        ram_vld[ram_addr[5:0]] <= 1'b1;
      end
      ram_rd_data <= ram_rd_en ? ram_get(ram_addr[5:0]) : 32'h0;
    end
  end

  // Reference model: arbitration mode, pending read return and expected memory image.
  int          n_tests = 0;
  int          n_fail  = 0;
  int          m_wait, m_burst, m_pend;
  bit          m_force;
  logic [31:0] m_pdata;
  logic [31:0] m_mem [0:63];
  logic [63:0] m_vld;
  logic        obs_gnt, obs_busy, obs_valid;
  logic [31:0] obs_c_rd, obs_d_rd;
  int          beats;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_get(input logic [AW-1:0] a);
    return m_vld[a[5:0]] ? m_mem[a[5:0]] : 32'h0;
  endfunction

  task automatic capture();
    obs_gnt   = d_gnt;
    obs_busy  = c_busy;
    obs_valid = d_rd_valid;
    obs_c_rd  = c_rd_data;
    obs_d_rd  = d_rd_data;
  endtask

  task automatic reset_step();
    rst_n = 1'b0;
    #2;
    capture();
    chk("rst_d_gnt", 32'(d_gnt), 32'd0);
    chk("rst_c_busy", 32'(c_busy), 32'd0);
    chk("rst_d_rd_valid", 32'(d_rd_valid), 32'd0);
    chk("rst_ram_en", 32'({ram_rd_en, ram_wr_en}), 32'd0);
    @(posedge clk);
    m_wait  = 0;
    m_burst = 0;
    m_force = 1'b0;
    m_pend  = 0;
    m_vld   = '0;
    @(negedge clk);
  endtask

  task automatic step();
    logic          core_req, dma, served, nf, e_wr, e_rd;
    logic [AW-1:0] e_addr;
    logic [31:0]   e_data;
    core_req = c_rd_en | c_wr_en;
    if (m_force)          dma = d_req;
    else if (m_burst > 0) dma = d_req & d_lock;
    else                  dma = d_req & ~core_req;
    served = core_req & ~dma;
    e_wr = 1'b0; e_rd = 1'b0; e_addr = '0; e_data = '0;
    if (dma) begin
      e_wr = d_we; e_rd = ~d_we; e_addr = d_addr; e_data = d_we ? d_wr_data : 32'h0;
    end else if (served) begin
      e_wr = c_wr_en; e_rd = ~c_wr_en; e_addr = c_addr; e_data = c_wr_en ? c_wr_data : 32'h0;
    end
    #2;
    capture();
    chk("d_gnt", 32'(d_gnt), 32'(dma));
    chk("c_busy", 32'(c_busy), 32'(core_req & dma));
    chk("d_rd_valid", 32'(d_rd_valid), 32'(m_pend == 2));
    chk("d_rd_data", d_rd_data, (m_pend == 2) ? m_pdata : 32'h0);
    chk("c_rd_data", c_rd_data, (m_pend == 1) ? m_pdata : 32'h0);
    chk("ram_en", 32'({ram_rd_en, ram_wr_en}), 32'({e_rd, e_wr}));
    chk("ram_addr", 32'(ram_addr), 32'(e_addr));
    chk("ram_wr_data", ram_wr_data, e_data);
    m_pend = 0;
    if (dma || served) begin
      if (e_wr) begin
        m_mem[e_addr[5:0]] = merge(m_get(e_addr), e_data, dma ? d_wr_strobe : c_wr_strobe);
        m_vld[e_addr[5:0]] = 1'b1;
      end else begin
        m_pend  = dma ? 2 : 1;
        m_pdata = m_get(e_addr);
      end
    end
    if (!d_req || dma) m_wait = 0;
    else if (m_wait < int'(MAX_WAIT)) m_wait++;
    nf = !m_force && (m_burst == 0) && core_req && d_req && (m_wait >= int'(MAX_WAIT));
    if (m_force)          m_burst = 0;
    else if (m_burst > 0) m_burst = (dma && (m_burst + 1 < int'(MAX_BURST))) ? m_burst + 1 : 0;
    else                  m_burst = (dma && d_lock && (MAX_BURST > 1)) ? 1 : 0;
    m_force = nf;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    c_rd_en = 0; c_wr_en = 0; c_addr = '0; c_wr_data = '0; c_wr_strobe = '0;
    d_req = 0; d_we = 0; d_lock = 0; d_addr = '0; d_wr_data = '0; d_wr_strobe = '0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    reset_step();
    reset_step();
    rst_n = 1'b1;

    // Core-only write then read.
    c_wr_en = 1; c_addr = AW'('h010); c_wr_data = 32'hCAFEF00D; c_wr_strobe = 4'hF;
    step();
    chk("core_wr_busy", 32'(obs_busy), 32'd0);
    c_wr_en = 0; c_rd_en = 1;
    step();
    chk("core_rd_busy", 32'(obs_busy), 32'd0);
    c_rd_en = 0;
    step();
    chk("core_rd_data", obs_c_rd, 32'hCAFEF00D);
    chk("core_only_gnt", 32'(obs_gnt), 32'd0);

    // Contention: DMA forced every fifth cycle.
    c_rd_en = 1; d_req = 1; d_we = 1; d_addr = AW'('h030);
    d_wr_data = 32'hA5A50001; d_wr_strobe = 4'hF;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("cont_gnt", 32'(obs_gnt), 32'(i % 5 == 4));
      chk("cont_busy", 32'(obs_busy), 32'(i % 5 == 4));
    end
`ifdef RAM_ARB_STATS_EN
    chk("stat_conflicts", stat_conflicts, 32'd20);
    chk("stat_forced", stat_forced, 32'd4);
`endif
    idle_inputs();
    step();

    // Idle core: DMA read returns next cycle.
    c_wr_en = 1; c_addr = AW'('h020); c_wr_data = 32'h12345678; c_wr_strobe = 4'hF;
    step();
    idle_inputs();
    d_req = 1; d_we = 0; d_addr = AW'('h020);
    step();
    chk("dma_rd_gnt", 32'(obs_gnt), 32'd1);
    idle_inputs();
    step();
    chk("dma_rd_valid", 32'(obs_valid), 32'd1);
    chk("dma_rd_data", obs_d_rd, 32'h12345678);
    chk("dma_rd_core_data", obs_c_rd, 32'h0);

    // Locked 10-beat burst against a busy core: 8 beats, then the core.
    beats = 0;
    d_req = 1; d_lock = 1; d_we = 1; d_wr_strobe = 4'hF; c_addr = AW'('h010);
    for (int i = 0; i < 24; i++) begin
      c_rd_en   = (i > 0);
      d_addr    = AW'('h030 + beats);
      d_wr_data = 32'hB0000000 + 32'(beats);
      step();
      if (i < 9) begin
        chk("burst_gnt", 32'(obs_gnt), 32'(i < 8));
        chk("burst_busy", 32'(obs_busy), 32'((i > 0) && (i < 8)));
      end
      if (obs_gnt) beats++;
      if (beats == 10) begin
        d_req = 0; d_lock = 0;
      end
    end
    chk("burst_beats", 32'(beats), 32'd10);
    idle_inputs();
    step();

    // Reset asserted on the third beat of a read burst.
    d_req = 1; d_lock = 1; d_we = 0; d_addr = AW'('h020);
    step();
    c_rd_en = 1;
    step();
    reset_step();
    rst_n = 1'b1;
    step();
    chk("post_rst_gnt", 32'(obs_gnt), 32'd0);
    chk("post_rst_busy", 32'(obs_busy), 32'd0);
    chk("post_rst_valid", 32'(obs_valid), 32'd0);
    idle_inputs();
    step();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      c_rd_en     = 1'($urandom_range(0, 1));
      c_wr_en     = ($urandom_range(0, 3) == 0);
      c_addr      = AW'($urandom_range(0, 15));
      c_wr_data   = $urandom;
      c_wr_strobe = 4'($urandom_range(0, 15));
      d_req       = ($urandom_range(0, 3) != 0);
      d_we        = 1'($urandom_range(0, 1));
      d_lock      = ($urandom_range(0, 2) != 0);
      d_addr      = AW'($urandom_range(0, 15));
      d_wr_data   = $urandom;
      d_wr_strobe = 4'($urandom_range(0, 15));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
